branch_pred: RTL and testbench

Perceptron branch predictor top-level for a TinyTapeout tile. A host presents the low byte of a branch instruction address, and the block returns a taken/not-taken prediction from one of 8 perceptrons indexed by that address. The host then supplies the resolved direction, and the block trains the perceptron and updates its global history register (GHR). It sits directly on the tile pins; weights live in internal flops.

---
 rtl/branch_pred_if.sv | 29 ++
 rtl/branch_pred.sv | 225 ++++++++++++++++++++++
 tb/tb_branch_pred.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_pred_if.sv
// ---------------------------------------------------------------------------
// branch_pred_if
// Tile pin bundle between the host (master) and the perceptron branch
// predictor (slave).
//   ena     : tile enable (host -> predictor, unused by the predictor)
//   ui_in   : instruction address low byte (host -> predictor)
//   uio_in  : [0] new_data_avail, [1] resolved direction (host -> predictor)
//   uo_out  : status / prediction / debug outputs (predictor -> host)
//   uio_out : debug index and weight write enable (predictor -> host)
//   uio_oe  : bidirectional pin output enables (predictor -> host)
// ---------------------------------------------------------------------------
interface branch_pred_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/branch_pred.sv
// ---------------------------------------------------------------------------
// branch_pred
// Perceptron branch predictor for a TinyTapeout tile. Eight perceptrons of
// HIST_LEN+1 saturating signed weights are indexed by address bits [4:2].
// A query accumulates one weight per cycle into y; the prediction is y >= 0.
// The resolved direction then trains the perceptron (one weight per cycle)
// when it mispredicted or |y| <= THETA, and shifts the global history.
// After reset the weights are zeroed one perceptron per cycle before any
// request is accepted.
//
// Ports:
//   clk     : clock, all logic on the rising edge
//   rst     : synchronous active-high reset
//   bus     : branch_pred_if.slave
//     uo_out[0] pred_ready      uo_out[1] prediction
//     uo_out[2] training_done   uo_out[3] mem_reset_done
//     uo_out[4] dbg new_data_avail rising edge
//     uo_out[6:5] dbg FSM state uo_out[7] dbg memory clear active
//     uio_out[4:2] dbg perceptron index, uio_out[5] dbg weight write enable
//
// Build option: define DEBUG_OUTPUTS_EN to drive the debug outputs and the
// uio output enables; otherwise those pins are held at zero.
// ---------------------------------------------------------------------------
module branch_pred #(
  parameter int HIST_LEN = 4,
  parameter int WEIGHT_W = 8,
  parameter int THETA    = 21
) (
  input  logic          clk,
  input  logic          rst,
  branch_pred_if.slave  bus
);

  localparam int N_W    = HIST_LEN + 1;
  localparam int STEP_W = $clog2(N_W + 1);
  localparam int Y_W    = 11;

  localparam logic signed [WEIGHT_W-1:0] W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic signed [WEIGHT_W-1:0] W_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};
  localparam logic signed [WEIGHT_W-1:0] W_ONE = {{(WEIGHT_W-1){1'b0}}, 1'b1};
  localparam logic signed [Y_W-1:0]      THETA_Y   = Y_W'(THETA);
  localparam logic [STEP_W-1:0]          LAST_STEP = STEP_W'(HIST_LEN);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COMPUTE    = 2'd1,
    WAIT_TRUTH = 2'd2,
    TRAIN      = 2'd3
  } state_e;

  // Move a weight one step toward up/down, clamped to the signed range.
  function automatic logic signed [WEIGHT_W-1:0] sat_step(
    input logic signed [WEIGHT_W-1:0] w,
    input logic                       up
  );
    logic signed [WEIGHT_W-1:0] r;
    if (up) begin
      r = (w == W_MAX) ? w : w + W_ONE;
    end else begin
      r = (w == W_MIN) ? w : w - W_ONE;
    end
    return r;
  endfunction

  state_e                     state_r;
  logic [2:0]                 idx_r;
  logic [STEP_W-1:0]          step_r;
  logic signed [Y_W-1:0]      y_r;
  logic [HIST_LEN-1:0]        ghr_r;
  logic                       t_r;
  logic                       pred_r;
  logic                       pred_ready_r;
  logic                       train_done_r;
  logic                       mem_done_r;
  logic                       clr_active_r;
  logic                       wr_en_r;
  logic                       nda_q_r;
  logic signed [WEIGHT_W-1:0] w_r [8][N_W];

  logic                       nda_rise_s;
  logic signed [WEIGHT_W-1:0] cur_w_s;
  logic                       hist_bit_s;
  logic signed [Y_W-1:0]      w_ext_s;
  logic signed [Y_W-1:0]      term_s;
  logic signed [Y_W-1:0]      y_next_s;
  logic                       y_small_s;
  logic                       train_need_s;
  logic signed [WEIGHT_W-1:0] upd_w_s;

  // Pins the predictor never looks at.
  logic unused_pins_s;
  assign unused_pins_s = &{1'b0, bus.ena, bus.ui_in[7:5], bus.ui_in[1:0], bus.uio_in[7:2]};

  // Rising edge of new_data_avail; forced low while in reset.
  assign nda_rise_s = bus.uio_in[0] & ~nda_q_r & ~rst;

  // Select the weight and history bit addressed by the current step.
  // Step 0 is the bias weight, whose history bit behaves as a constant 1.
  always_comb begin
    cur_w_s    = {WEIGHT_W{1'b0}};
    hist_bit_s = 1'b1;
    for (int k = 0; k < N_W; k++) begin
      cur_w_s = (step_r == STEP_W'(k)) ? w_r[idx_r][k] : cur_w_s;
    end
    for (int i = 0; i < HIST_LEN; i++) begin
      hist_bit_s = (step_r == STEP_W'(i + 1)) ? ghr_r[i] : hist_bit_s;
    end
  end

  assign w_ext_s  = {{(Y_W-WEIGHT_W){cur_w_s[WEIGHT_W-1]}}, cur_w_s};
  assign term_s   = hist_bit_s ? w_ext_s : -w_ext_s;
  assign y_next_s = y_r + term_s;

  // Train on a mispredict or a low-confidence output.
  assign y_small_s    = (y_r <= THETA_Y) && (y_r >= -THETA_Y);
  assign train_need_s = (pred_r != bus.uio_in[1]) || y_small_s;

  // Weight moves up when the outcome agrees with the history bit (or, for
  // the bias weight, when the branch was taken).
  assign upd_w_s = sat_step(cur_w_s, t_r == hist_bit_s);

  // Memory clear sequencer, prediction/training FSM and weight storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      idx_r        <= 3'd0;
      step_r       <= {STEP_W{1'b0}};
      y_r          <= {Y_W{1'b0}};
      ghr_r        <= {HIST_LEN{1'b0}};
      t_r          <= 1'b0;
      pred_r       <= 1'b0;
      pred_ready_r <= 1'b0;
      train_done_r <= 1'b0;
      mem_done_r   <= 1'b0;
      clr_active_r <= 1'b0;
      wr_en_r      <= 1'b0;
      nda_q_r      <= 1'b0;
    end else begin
      nda_q_r <= bus.uio_in[0];
      if (!mem_done_r) begin
        if (!clr_active_r) begin
          clr_active_r <= 1'b1;
          idx_r        <= 3'd0;
          wr_en_r      <= 1'b1;
        end else begin
          for (int k = 0; k < N_W; k++) begin
            w_r[idx_r][k] <= {WEIGHT_W{1'b0}};
          end
          if (idx_r == 3'd7) begin
            clr_active_r <= 1'b0;
            wr_en_r      <= 1'b0;
            mem_done_r   <= 1'b1;
            idx_r        <= 3'd0;
          end else begin
            idx_r <= idx_r + 3'd1;
          end
        end
      end else begin
        case (state_r)
          IDLE: begin
            if (nda_rise_s) begin
              state_r      <= COMPUTE;
              idx_r        <= bus.ui_in[4:2];
              step_r       <= {STEP_W{1'b0}};
              y_r          <= {Y_W{1'b0}};
              pred_ready_r <= 1'b0;
              train_done_r <= 1'b0;
            end
          end
          COMPUTE: begin
            y_r <= y_next_s;
            if (step_r == LAST_STEP) begin
              pred_r       <= ~y_next_s[Y_W-1];
              pred_ready_r <= 1'b1;
              step_r       <= {STEP_W{1'b0}};
              state_r      <= WAIT_TRUTH;
            end else begin
              step_r <= step_r + {{(STEP_W-1){1'b0}}, 1'b1};
            end
          end
          WAIT_TRUTH: begin
            if (nda_rise_s) begin
              state_r      <= TRAIN;
              t_r          <= bus.uio_in[1];
              pred_ready_r <= 1'b0;
              wr_en_r      <= train_need_s;
              step_r       <= {STEP_W{1'b0}};
            end
          end
          TRAIN: begin
            for (int k = 0; k < N_W; k++) begin
              if (wr_en_r && (step_r == STEP_W'(k))) begin
                w_r[idx_r][k] <= upd_w_s;
              end
            end
            if (step_r == LAST_STEP) begin
              ghr_r        <= {ghr_r[HIST_LEN-2:0], t_r};
              train_done_r <= 1'b1;
              wr_en_r      <= 1'b0;
              step_r       <= {STEP_W{1'b0}};
              state_r      <= IDLE;
            end else begin
              step_r <= step_r + {{(STEP_W-1){1'b0}}, 1'b1};
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef DEBUG_OUTPUTS_EN
  assign bus.uo_out  = {clr_active_r, state_r, nda_rise_s, mem_done_r,
                        train_done_r, pred_r, pred_ready_r};
  assign bus.uio_out = {2'b00, wr_en_r, idx_r, 2'b00};
  assign bus.uio_oe  = 8'b0011_1100;
`else
  assign bus.uo_out  = {4'b0000, mem_done_r, train_done_r, pred_r, pred_ready_r};
  assign bus.uio_out = 8'b0000_0000;
  assign bus.uio_oe  = 8'b0000_0000;
`endif

endmodule

// File: tb/tb_branch_pred.sv
// ---------------------------------------------------------------------------
// tb_branch_pred
// Directed bench for branch_pred: reset / memory clear, a table of
// query+train transactions with hand-computed predictions, ignored edges
// during COMPUTE, and reset in the middle of training. Debug pins are checked
// when DEBUG_OUTPUTS_EN is defined, otherwise they must read zero.
// ---------------------------------------------------------------------------
module tb_branch_pred;

  logic clk;
  logic rst;

  branch_pred_if bus ();

  branch_pred dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] addr;
    logic       truth;
    logic       exp_pred;
    logic       exp_train;
  } vec_t;

  vec_t vecs [13];

  int   n_cmp;
  int   n_fail;
  int   lat;
  int   wr_cycles;
  int   train_cycles;
  int   bad_states;
  logic got_pred;
  logic done;
  logic [1:0] st;
  logic [1:0] prev_st;

`ifdef DEBUG_OUTPUTS_EN
  localparam logic [7:0] EXP_OE = 8'b0011_1100;
`else
  localparam logic [7:0] EXP_OE = 8'b0000_0000;
`endif

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Raise new_data_avail for one cycle with the address, wait for pred_ready.
  task automatic do_query(input logic [7:0] addr);
    bus.ui_in     = addr;
    bus.uio_in[0] = 1'b1;
`ifdef DEBUG_OUTPUTS_EN
    #1;
    check("dbg_rise", int'(bus.uo_out[4]), 1);
`endif
    lat  = 0;
    done = 1'b0;
    while (lat < 30 && !done) begin
      @(negedge clk);
      lat++;
      bus.uio_in[0] = 1'b0;
      done = bus.uo_out[0];
    end
    got_pred = bus.uo_out[1];
  endtask

  // Present the resolved direction, wait for training_done.
  task automatic do_truth(input logic t);
    bus.uio_in[1] = t;
    bus.uio_in[0] = 1'b1;
    lat          = 0;
    wr_cycles    = 0;
    train_cycles = 0;
    done         = 1'b0;
    while (lat < 30 && !done) begin
      @(negedge clk);
      lat++;
      bus.uio_in[0] = 1'b0;
      if (bus.uo_out[6:5] == 2'd3) train_cycles++;
      if (bus.uio_out[5]) wr_cycles++;
      done = bus.uo_out[2];
    end
  endtask

  // Hold reset, check the quiet outputs, then follow the memory clear.
  task automatic do_reset(input logic hold_nda);
    int k;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_uo_out", int'(bus.uo_out), 0);
    check("rst_uio_out", int'(bus.uio_out), 0);
    check("rst_uio_oe", int'(bus.uio_oe), int'(EXP_OE));
    rst  = 1'b0;
    k    = 0;
    done = 1'b0;
    while (k < 30 && !done) begin
      @(negedge clk);
      k++;
      if (hold_nda && k == 2) bus.uio_in[0] = 1'b1;
      done = bus.uo_out[3];
`ifdef DEBUG_OUTPUTS_EN
      if (k <= 8) begin
        check($sformatf("clr_idx_%0d", k), int'(bus.uio_out[4:2]), k - 1);
        check($sformatf("clr_wr_%0d", k), int'(bus.uio_out[5]), 1);
        check($sformatf("clr_act_%0d", k), int'(bus.uo_out[7]), 1);
      end
`endif
    end
    check("clr_done_edge", k, 9);
    check("clr_uo_low", int'(bus.uo_out[2:0]), 0);
`ifdef DEBUG_OUTPUTS_EN
    check("clr_act_off", int'(bus.uo_out[7]), 0);
    check("clr_wr_off", int'(bus.uio_out[5]), 0);
`else
    check("nodbg_uo_hi", int'(bus.uo_out[7:4]), 0);
    check("nodbg_uio_out", int'(bus.uio_out), 0);
`endif
    if (hold_nda) begin
      repeat (8) @(negedge clk);
      check("held_nda_no_query", int'(bus.uo_out[0]), 0);
      check("held_nda_idle", int'(bus.uo_out[6:5]), 0);
      bus.uio_in[0] = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    // Weights (w0..w4) and GHR are tracked by hand in the comments.
    vecs[0]  = '{8'h04, 1'b0, 1'b1, 1'b1}; // idx1 y=0 -> w -1,1,1,1,1
    vecs[1]  = '{8'h87, 1'b0, 1'b0, 1'b1}; // idx1 y=-5 -> -2,2,2,2,2
    vecs[2]  = '{8'h08, 1'b1, 1'b1, 1'b1}; // idx2 y=0  ghr->0001
    vecs[3]  = '{8'h0B, 1'b1, 1'b1, 1'b1}; // y=3  ghr->0011
    vecs[4]  = '{8'hE8, 1'b1, 1'b1, 1'b1}; // y=4  ghr->0111
    vecs[5]  = '{8'h08, 1'b1, 1'b1, 1'b1}; // y=3  ghr->1111
    vecs[6]  = '{8'h09, 1'b1, 1'b1, 1'b1}; // y=0
    vecs[7]  = '{8'h08, 1'b1, 1'b1, 1'b1}; // y=5
    vecs[8]  = '{8'h0A, 1'b1, 1'b1, 1'b1}; // y=10
    vecs[9]  = '{8'h08, 1'b1, 1'b1, 1'b1}; // y=15
    vecs[10] = '{8'h48, 1'b1, 1'b1, 1'b1}; // y=20 -> 9,7,5,3,1
    vecs[11] = '{8'h08, 1'b1, 1'b1, 1'b0}; // y=25 confident, no training
    vecs[12] = '{8'h08, 1'b1, 1'b1, 1'b0}; // y=25 again

    rst        = 1'b1;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;

    do_reset(1'b1);

    for (int i = 0; i < 13; i++) begin
      do_query(vecs[i].addr);
      check($sformatf("v%0d_pred_lat", i), lat, 6);
      check($sformatf("v%0d_pred", i), int'(got_pred), int'(vecs[i].exp_pred));
      check($sformatf("v%0d_tdone_clr", i), int'(bus.uo_out[2]), 0);
      do_truth(vecs[i].truth);
      check($sformatf("v%0d_train_lat", i), lat, 6);
      check($sformatf("v%0d_rdy_clr", i), int'(bus.uo_out[0]), 0);
`ifdef DEBUG_OUTPUTS_EN
      check($sformatf("v%0d_train_cyc", i), train_cycles, 5);
      check($sformatf("v%0d_wr_cyc", i), wr_cycles, vecs[i].exp_train ? 5 : 0);
`endif
    end

    // Second rising edge during COMPUTE, then new_data_avail held high.
    bus.ui_in     = 8'h08;
    bus.uio_in[0] = 1'b1;
    lat        = 0;
    done       = 1'b0;
    bad_states = 0;
    prev_st    = 2'd1;
    while (lat < 30 && !done) begin
      @(negedge clk);
      lat++;
      bus.uio_in[0] = (lat >= 2);
      st = bus.uo_out[6:5];
      if (st == 2'd0 || st == 2'd3 || (st == 2'd1 && prev_st == 2'd2)) bad_states++;
      prev_st = st;
      done = bus.uo_out[0];
    end
    check("glitch_pred_lat", lat, 6);
    check("glitch_pred", int'(bus.uo_out[1]), 1);
    repeat (8) begin
      @(negedge clk);
      st = bus.uo_out[6:5];
      if (st != 2'd2) bad_states++;
    end
    check("glitch_rdy_held", int'(bus.uo_out[0]), 1);
    check("glitch_no_train", int'(bus.uo_out[2]), 0);
`ifdef DEBUG_OUTPUTS_EN
    check("glitch_states", bad_states, 0);
`endif
    bus.uio_in[0] = 1'b0;
    @(negedge clk);
    do_truth(1'b1);
    check("glitch_train_lat", lat, 6);
`ifdef DEBUG_OUTPUTS_EN
    check("glitch_wr_cyc", wr_cycles, 0);
`endif

    // idx1 with GHR=1111: y = -2+2+2+2+2 = 6; reset lands mid-TRAIN.
    do_query(8'h04);
    check("pre_rst_pred", int'(got_pred), 1);
    bus.uio_in[1] = 1'b0;
    bus.uio_in[0] = 1'b1;
    @(negedge clk);
    bus.uio_in[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
`ifdef DEBUG_OUTPUTS_EN
    check("mid_train_state", int'(bus.uo_out[6:5]), 3);
    check("mid_train_wr", int'(bus.uio_out[5]), 1);
`endif
    do_reset(1'b0);

    // Everything re-zeroed, GHR cleared.
    do_query(8'h14);
    check("post_rst_idx5_pred", int'(got_pred), 1);
    do_truth(1'b0);
    check("post_rst_idx5_lat", lat, 6);
    do_query(8'h04);
    check("post_rst_idx1_pred", int'(got_pred), 1);
    do_truth(1'b0);
`ifdef DEBUG_OUTPUTS_EN
    check("post_rst_idx1_wr", wr_cycles, 5);
`endif
    do_query(8'h84);
    check("post_rst_idx1_y_m5", int'(got_pred), 0);
    do_truth(1'b0);
    check("post_rst_last_lat", lat, 6);
    check("final_uio_oe", int'(bus.uio_oe), int'(EXP_OE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
